// File: rtl/storage_pkg.sv
// Shared definitions for the storage-array companion blocks.
package storage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } load_state_e;

endpackage

// File: rtl/rom_stream_loader.sv
// Streams a counted run of words from a valid/ready source into a synchronous write port,
// starting at a commanded base address and wrapping modulo DEPTH.
module rom_stream_loader
  import storage_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned DEPTH  = 2**4,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [CNT_W-1:0]  cmd_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  s_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  load_state_e       state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] addr_next;

  // Explicit wrap keeps non-power-of-two depths inside the array.
  always_comb begin
    addr_next = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    s_ready   = (state == ST_LOAD);
    busy      = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_base;
            remaining <= cmd_len;
            if (cmd_len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (s_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= s_data;
            addr      <= addr_next;
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
